// File: rtl/axi4s_pattern_source.sv
// AXI4-Stream raster test-pattern source: emits X_NUM x Y_NUM frames whose pixels carry a {frame, y, x} code,
// with tuser on the first pixel of a frame and tlast on the last pixel of each line. Start/stop is frame-granular.
module axi4s_pattern_source #(
    parameter int DATA_WIDTH  = 32,
    parameter int X_NUM       = 640,
    parameter int Y_NUM       = 480,
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 9,
    parameter int FRAME_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] m_axi4s_tdata,
    output logic                  m_axi4s_tlast,
    output logic                  m_axi4s_tuser,
    output logic                  m_axi4s_tvalid,
    input  logic                  m_axi4s_tready
);

    localparam int CODE_WIDTH = FRAME_WIDTH + Y_WIDTH + X_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [X_WIDTH-1:0]     r_x;
    logic [Y_WIDTH-1:0]     r_y;
    logic [FRAME_WIDTH-1:0] r_frame;
    logic                   w_run;
    logic                   w_xfer;
    logic                   w_last_x;
    logic                   w_last_y;
    logic [CODE_WIDTH-1:0]  w_code;

    assign w_last_x = (r_x == X_WIDTH'(X_NUM - 1));
    assign w_last_y = (r_y == Y_WIDTH'(Y_NUM - 1));
    assign w_xfer   = w_run & m_axi4s_tready;
    assign w_code   = {r_frame, r_y, r_x};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: enable only matters when idle or on the final pixel of a frame
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_xfer && w_last_x && w_last_y && !enable) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: busy and tvalid are both exactly "in RUN"
    always_comb begin
        w_run = 1'b0;
        case (r_state)
            ST_RUN:  w_run = 1'b1;
            ST_IDLE: w_run = 1'b0;
            default: w_run = 1'b0;
        endcase
    end

    // Raster counters advance only on an accepted beat, so stalls hold the pixel stable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x     <= {X_WIDTH{1'b0}};
            r_y     <= {Y_WIDTH{1'b0}};
            r_frame <= {FRAME_WIDTH{1'b0}};
        end else if (w_xfer) begin
            if (!w_last_x) begin
                r_x <= r_x + {{(X_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_x <= {X_WIDTH{1'b0}};
                if (!w_last_y) begin
                    r_y <= r_y + {{(Y_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    r_y     <= {Y_WIDTH{1'b0}};
                    r_frame <= r_frame + {{(FRAME_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    generate
        if (DATA_WIDTH > CODE_WIDTH) begin : g_zext
            assign m_axi4s_tdata = {{(DATA_WIDTH-CODE_WIDTH){1'b0}}, w_code};
        end else begin : g_trunc
            assign m_axi4s_tdata = w_code[DATA_WIDTH-1:0];
        end
    endgenerate

    assign busy           = w_run;
    assign m_axi4s_tvalid = w_run;
    assign m_axi4s_tlast  = w_last_x;
    assign m_axi4s_tuser  = (r_x == {X_WIDTH{1'b0}}) && (r_y == {Y_WIDTH{1'b0}});

endmodule

// File: tb/tb_axi4s_pattern_source.sv
// Directed bench for axi4s_pattern_source: a 4x3 raster (2-bit frame counter) and a 1x2 raster (1-bit frame counter).
module tb_axi4s_pattern_source;

    logic        clk = 1'b0;
    logic        rst, en, rdy;
    logic        busy0, valid0, last0, user0;
    logic [15:0] data0;
    logic        rst1, en1, rdy1;
    logic        busy1, valid1, last1, user1;
    logic [3:0]  data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi4s_pattern_source #(
        .DATA_WIDTH(16), .X_NUM(4), .Y_NUM(3), .X_WIDTH(2), .Y_WIDTH(2), .FRAME_WIDTH(2)
    ) dut0 (
        .clk(clk), .reset(rst), .enable(en), .busy(busy0),
        .m_axi4s_tdata(data0), .m_axi4s_tlast(last0), .m_axi4s_tuser(user0),
        .m_axi4s_tvalid(valid0), .m_axi4s_tready(rdy)
    );

    axi4s_pattern_source #(
        .DATA_WIDTH(4), .X_NUM(1), .Y_NUM(2), .X_WIDTH(1), .Y_WIDTH(1), .FRAME_WIDTH(1)
    ) dut1 (
        .clk(clk), .reset(rst1), .enable(en1), .busy(busy1),
        .m_axi4s_tdata(data1), .m_axi4s_tlast(last1), .m_axi4s_tuser(user1),
        .m_axi4s_tvalid(valid1), .m_axi4s_tready(rdy1)
    );

    typedef struct {
        logic        rst, en, rdy;
        logic        valid, busy;
        logic [15:0] data;
        logic        last, user;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic y, input logic v, input logic b,
                       input logic [15:0] d, input logic l, input logic u);
        vec_t t;
        t.rst = r; t.en = e; t.rdy = y; t.valid = v; t.busy = b; t.data = d; t.last = l; t.user = u;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic v, input logic b, input logic [15:0] d,
                        input logic l, input logic u);
        chk({tag, ".tvalid"}, {31'd0, valid0}, {31'd0, v});
        chk({tag, ".busy"},   {31'd0, busy0},  {31'd0, b});
        chk({tag, ".tdata"},  {16'd0, data0},  {16'd0, d});
        chk({tag, ".tlast"},  {31'd0, last0},  {31'd0, l});
        chk({tag, ".tuser"},  {31'd0, user0},  {31'd0, u});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ex, ey, ef, n, cyc;
        logic [3:0] exp1_data [5];
        logic       exp1_user [5];

        rst = 1'b1; en = 1'b0; rdy = 1'b0;
        rst1 = 1'b1; en1 = 1'b0; rdy1 = 1'b0;

        // reset, idle, start latency, mid-frame enable drop, stalls, full frame 0, seamless frame 1
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0,  1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0,  1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2,  1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd3,  1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3,  1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd4,  1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd5,  1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd6,  1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd7,  1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd8,  1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd9,  1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd10, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd11, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd16, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; en = vecs[i].en; rdy = vecs[i].rdy;
            step();
            chk0($sformatf("vec%0d", i), vecs[i].valid, vecs[i].busy, vecs[i].data, vecs[i].last, vecs[i].user);
        end

        // frame 1 with enable low: completes fully, then idles showing frame 2 origin
        en = 1'b0; rdy = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk0($sformatf("f1beat%0d", k), 1'b1, 1'b1, 16'(16 + k), (k % 4) == 3, 1'b0);
        end
        step();
        chk0("f1end", 1'b0, 1'b0, 16'd32, 1'b0, 1'b1);
        step();
        chk0("idle_hold", 1'b0, 1'b0, 16'd32, 1'b0, 1'b1);

        // random backpressure, enable held for two frames then dropped during the third
        ex = 0; ey = 0; ef = 2; n = 0; cyc = 0;
        en = 1'b1; rdy = 1'b0;
        step();
        while (n < 36 && cyc < 400) begin
            chk("rnd.tvalid", {31'd0, valid0}, 32'd1);
            chk("rnd.tdata", {16'd0, data0}, 32'((ef << 4) | (ey << 2) | ex));
            chk("rnd.tlast", {31'd0, last0}, {31'd0, ex == 3});
            chk("rnd.tuser", {31'd0, user0}, {31'd0, ex == 0 && ey == 0});
            rdy = 1'($urandom_range(0, 1));
            en  = (n < 30);
            if (rdy) begin
                n++;
                if (ex < 3) ex++;
                else begin
                    ex = 0;
                    if (ey < 2) ey++;
                    else begin ey = 0; ef = (ef + 1) % 4; end
                end
            end
            step();
            cyc++;
        end
        chk("rnd.budget", {31'd0, n == 36}, 32'd1);
        chk0("rnd.end", 1'b0, 1'b0, 16'(ef << 4), 1'b0, 1'b1);

        // reset at pixel (1,1) abandons the frame; restart is at frame 0
        en = 1'b1; rdy = 1'b1;
        step();
        for (int k = 0; k < 5; k++) step();
        chk0("pre_rst", 1'b1, 1'b1, 16'h0015, 1'b0, 1'b0);
        rst = 1'b1; en = 1'b0;
        step();
        chk0("mid_rst", 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        rst = 1'b0; en = 1'b1;
        step();
        chk0("re_en", 1'b1, 1'b1, 16'd0, 1'b0, 1'b1);
        en = 1'b0;

        // single-pixel lines, two lines, one-bit frame counter that wraps
        exp1_data[0] = 4'd0; exp1_data[1] = 4'd2; exp1_data[2] = 4'd4; exp1_data[3] = 4'd6; exp1_data[4] = 4'd0;
        exp1_user[0] = 1'b1; exp1_user[1] = 1'b0; exp1_user[2] = 1'b1; exp1_user[3] = 1'b0; exp1_user[4] = 1'b1;
        step();
        rst1 = 1'b0; en1 = 1'b1; rdy1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("x1.tvalid%0d", k), {31'd0, valid1}, 32'd1);
            chk($sformatf("x1.tdata%0d", k),  {28'd0, data1},  {28'd0, exp1_data[k]});
            chk($sformatf("x1.tlast%0d", k),  {31'd0, last1},  32'd1);
            chk($sformatf("x1.tuser%0d", k),  {31'd0, user1},  {31'd0, exp1_user[k]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
